// File: rtl/cable_sensor_qual.sv
// Cable presence sensor front-end: synchronise and debounce raw_sense, then qualify
// presence dwell into detect/flag, count confirmed cables and latch a stuck-sensor fault.
module cable_sensor_qual #(
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned MIN_PRESENT = 1000,
   parameter int unsigned MAX_PRESENT = 100000,
   parameter int unsigned TMR_W       = 20,
   parameter int unsigned COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en_sensor,
   input  logic               raw_sense,
   output logic               detect,
   output logic               flag,
   output logic               fault,
   output logic [COUNT_W-1:0] cable_count
);

   localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [TMR_W-1:0] MIN_LAST = TMR_W'(MIN_PRESENT - 1);
   localparam logic [TMR_W-1:0] MAX_LAST = TMR_W'(MAX_PRESENT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_PRESENT,
      ST_CONFIRMED,
      ST_FAULT
   } state_t;

   state_t            state;
   logic              s1, s2;
   logic              deb_level;
   logic [DW-1:0]     deb_cnt;
   logic [TMR_W-1:0]  ptimer;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         deb_level <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         s1 <= raw_sense;
         s2 <= s1;
         if (s2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   // Outputs are loaded together with the state they decode, so they stay pure Moore.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         ptimer      <= '0;
         cable_count <= '0;
         detect      <= 1'b0;
         flag        <= 1'b0;
         fault       <= 1'b0;
      end else if (!en_sensor) begin
         state  <= ST_IDLE;
         ptimer <= '0;
         detect <= 1'b0;
         flag   <= 1'b0;
         fault  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (deb_level) begin
                  state  <= ST_PRESENT;
                  ptimer <= '0;
                  detect <= 1'b1;
               end
            end
            ST_PRESENT: begin
               ptimer <= ptimer + TMR_W'(1);
               if (!deb_level) begin
                  state  <= ST_WAIT;
                  detect <= 1'b0;
               end else if (ptimer == MIN_LAST) begin
                  state       <= ST_CONFIRMED;
                  flag        <= 1'b1;
                  cable_count <= cable_count + COUNT_W'(1);
               end
            end
            ST_CONFIRMED: begin
               // Timer is held at MAX_LAST on entry to FAULT so it never exceeds it.
               if (!deb_level) begin
                  state  <= ST_WAIT;
                  ptimer <= ptimer + TMR_W'(1);
                  detect <= 1'b0;
                  flag   <= 1'b0;
               end else if (ptimer == MAX_LAST) begin
                  state  <= ST_FAULT;
                  detect <= 1'b0;
                  flag   <= 1'b0;
                  fault  <= 1'b1;
               end else begin
                  ptimer <= ptimer + TMR_W'(1);
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state  <= ST_IDLE;
               ptimer <= '0;
               detect <= 1'b0;
               flag   <= 1'b0;
               fault  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cable_sensor_qual.sv
// Directed bench for cable_sensor_qual: one instance with a long debounce (16) and one
// with a short debounce (4), both MIN_PRESENT=8, MAX_PRESENT=32, COUNT_W=2, sharing stimulus.
module tb_cable_sensor_qual;

   logic       clk = 1'b0;
   logic       resetn;
   logic       en_sensor;
   logic       raw_sense;

   logic       det16, flg16, flt16;
   logic [1:0] cnt16;
   logic       det4, flg4, flt4;
   logic [1:0] cnt4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cable_sensor_qual #(
      .DEB_CYCLES(16), .MIN_PRESENT(8), .MAX_PRESENT(32), .TMR_W(6), .COUNT_W(2)
   ) u16 (
      .clk(clk), .resetn(resetn), .en_sensor(en_sensor), .raw_sense(raw_sense),
      .detect(det16), .flag(flg16), .fault(flt16), .cable_count(cnt16)
   );

   cable_sensor_qual #(
      .DEB_CYCLES(4), .MIN_PRESENT(8), .MAX_PRESENT(32), .TMR_W(6), .COUNT_W(2)
   ) u4 (
      .clk(clk), .resetn(resetn), .en_sensor(en_sensor), .raw_sense(raw_sense),
      .detect(det4), .flag(flg4), .fault(flt4), .cable_count(cnt4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [1:0] exp_cnt;

   initial begin
      // Test 1: reset with sensor already covered and enable high
      resetn = 1'b0; en_sensor = 1'b1; raw_sense = 1'b1;
      #3;
      check("rst_det4", det4, 0); check("rst_flg4", flg4, 0); check("rst_flt4", flt4, 0);
      check("rst_cnt4", cnt4, 0); check("rst_det16", det16, 0); check("rst_cnt16", cnt16, 0);
      ticks(2);
      check("rst_hold_det4", det4, 0); check("rst_hold_det16", det16, 0);
      resetn = 1'b1;
      ticks(6);  check("u4_det_t6", det4, 0);
      ticks(1);  check("u4_det_t7", det4, 1);
      ticks(7);  check("u4_flg_t14", flg4, 0); check("u4_cnt_t14", cnt4, 0);
      ticks(1);  check("u4_flg_t15", flg4, 1); check("u4_cnt_t15", cnt4, 1);
      ticks(3);  check("u16_det_t18", det16, 0);
      ticks(1);  check("u16_det_t19", det16, 1);

      // Test 5: held presence runs into the stuck-sensor fault
      ticks(19);
      check("u4_flt_t38", flt4, 0); check("u4_det_t38", det4, 1); check("u4_flg_t38", flg4, 1);
      ticks(1);
      check("u4_flt_t39", flt4, 1); check("u4_det_t39", det4, 0); check("u4_flg_t39", flg4, 0);
      check("u4_cnt_t39", cnt4, 1);
      ticks(11); check("u16_flt_t50", flt16, 0);
      ticks(1);  check("u16_flt_t51", flt16, 1); check("u16_det_t51", det16, 0);
      check("u16_cnt_t51", cnt16, 1);
      en_sensor = 1'b0;
      ticks(1);
      check("u4_flt_clr", flt4, 0); check("u16_flt_clr", flt16, 0); check("u4_det_idle", det4, 0);
      en_sensor = 1'b1;
      ticks(2);  check("u4_reaccept", det4, 1); check("u16_reaccept", det16, 1);
      ticks(7);  check("u4_flg_pre", flg4, 0);
      ticks(1);  check("u4_flg_re", flg4, 1); check("u4_cnt_re", cnt4, 2); check("u16_cnt_re", cnt16, 2);

      // Enable dropped while confirmed
      en_sensor = 1'b0;
      ticks(1);
      check("en_drop_det", det4, 0); check("en_drop_flg", flg4, 0); check("en_drop_cnt", cnt4, 2);
      raw_sense = 1'b0;
      ticks(30);
      en_sensor = 1'b1;
      ticks(3);
      check("quiet_det4", det4, 0); check("quiet_det16", det16, 0); check("quiet_cnt4", cnt4, 2);

      // Test 2: 10-cycle pulse is shorter than the 16-cycle debounce
      raw_sense = 1'b1;
      ticks(10);
      raw_sense = 1'b0;
      for (int i = 0; i < 30; i++) begin
         ticks(1);
         check("glitch_det16", det16, 0);
      end
      check("glitch_cnt16", cnt16, 2);
      check("pulse10_cnt4", cnt4, 3);

      // Test 3: cable held 20 cycles on the short-debounce instance
      ticks(5);
      raw_sense = 1'b1;
      ticks(6);  check("c20_det_t6", det4, 0);
      ticks(1);  check("c20_det_t7", det4, 1);
      ticks(7);  check("c20_flg_t14", flg4, 0);
      ticks(1);  check("c20_flg_t15", flg4, 1); check("c20_cnt_wrap", cnt4, 0);
      ticks(5);
      raw_sense = 1'b0;
      ticks(6);  check("c20_det_t26", det4, 1); check("c20_flg_t26", flg4, 1);
      ticks(1);  check("c20_det_t27", det4, 0); check("c20_flg_t27", flg4, 0);
      ticks(30);

      // Test 4: short object, 5 cycles
      raw_sense = 1'b1;
      ticks(5);
      raw_sense = 1'b0;
      ticks(2);  check("c5_det_t7", det4, 1); check("c5_flg_t7", flg4, 0);
      ticks(4);  check("c5_det_t11", det4, 1); check("c5_flg_t11", flg4, 0);
      ticks(1);  check("c5_det_t12", det4, 0); check("c5_flg_t12", flg4, 0);
      ticks(30); check("c5_cnt", cnt4, 0);

      // Boundary: presence of exactly MIN_PRESENT cycles loses to the fall; one more confirms
      raw_sense = 1'b1;
      ticks(8);
      raw_sense = 1'b0;
      ticks(30); check("c8_cnt", cnt4, 0);
      raw_sense = 1'b1;
      ticks(9);
      raw_sense = 1'b0;
      ticks(30); check("c9_cnt", cnt4, 1);

      // Test 6: 2-bit counter wrap across five more cables
      exp_cnt = 2'd1;
      for (int i = 0; i < 5; i++) begin
         raw_sense = 1'b1;
         ticks(12);
         raw_sense = 1'b0;
         ticks(30);
         exp_cnt = exp_cnt + 2'd1;
         check("wrap_cnt", cnt4, exp_cnt);
      end
      check("u16_cnt_filtered", cnt16, 3);

      // Enable drop on the same edge as the confirm threshold
      raw_sense = 1'b1;
      ticks(14); check("thr_det", det4, 1); check("thr_flg", flg4, 0);
      en_sensor = 1'b0;
      ticks(1);  check("thr_en_det", det4, 0); check("thr_en_cnt", cnt4, 2);
      en_sensor = 1'b1;
      ticks(2);  check("thr_re_det", det4, 1);
      ticks(8);  check("thr_re_flg", flg4, 1); check("thr_re_cnt", cnt4, 3);

      // Asynchronous reset mid-operation
      #2;
      resetn = 1'b0;
      #1;
      check("arst_cnt4", cnt4, 0); check("arst_det4", det4, 0); check("arst_flg4", flg4, 0);
      check("arst_cnt16", cnt16, 0);
      ticks(2);
      resetn = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
